// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer sharing one synchronous RAM between an
// instruction-fetch port (0) and a load/store port (1), with optional clear after reset.
module ram_arbiter #(
   parameter int              AW             = 8,
   parameter int              DW             = 16,
   parameter bit              CLEAR_ON_RESET = 1'b1,
   parameter logic [DW-1:0]   INIT_DATA      = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          init_done,
   output logic          ram_w_en,
   output logic [AW-1:0] ram_w_addr,
   output logic [AW-1:0] ram_r_addr,
   output logic [DW-1:0] ram_w_data,
   input  logic [DW-1:0] ram_r_data
);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t        state, state_nxt;
   logic          prio;
   logic [AW-1:0] clr_addr;
   logic          vld_p1, port_p1, vld_p2, port_p2;
   logic          xfer, sel, sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      else        state <= state_nxt;
   end

   // Grants are combinational and gated by reset so nothing transfers mid-reset.
   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      init_done = 1'b0;
      if (state == S_CLEAR && clr_addr == '1) state_nxt = S_RUN;
      if (rst_n && state == S_RUN) begin
         init_done = 1'b1;
         gnt0      = req0 & (~req1 | ~prio);
         gnt1      = req1 & (~req0 | prio);
      end
   end

   assign xfer      = gnt0 | gnt1;
   assign sel       = gnt1;
   assign sel_we    = sel ? we1    : we0;
   assign sel_addr  = sel ? addr1  : addr0;
   assign sel_wdata = sel ? wdata1 : wdata0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ram_w_en   <= 1'b0;
         ram_w_addr <= '0;
         ram_r_addr <= '0;
         ram_w_data <= '0;
         clr_addr   <= '0;
         prio       <= 1'b0;
         vld_p1     <= 1'b0;
         port_p1    <= 1'b0;
         vld_p2     <= 1'b0;
         port_p2    <= 1'b0;
      end else begin
         // stage p1: request registered onto RAM inputs, read tag launched
         if (state == S_CLEAR) begin
            ram_w_en   <= 1'b1;
            ram_w_addr <= clr_addr;
            ram_w_data <= INIT_DATA;
            clr_addr   <= clr_addr + 1'b1;
            vld_p1     <= 1'b0;
         end else begin
            ram_w_en <= 1'b0;
            vld_p1   <= 1'b0;
            if (xfer) begin
               prio    <= ~sel;
               port_p1 <= sel;
               if (sel_we) begin
                  ram_w_en   <= 1'b1;
                  ram_w_addr <= sel_addr;
                  ram_w_data <= sel_wdata;
               end else begin
                  ram_r_addr <= sel_addr;
                  vld_p1     <= 1'b1;
               end
            end
         end
         // stage p2: tag aligned with RAM read data
         vld_p2  <= vld_p1;
         port_p2 <= port_p1;
      end
   end

   assign rvalid0 = vld_p2 & ~port_p2;
   assign rvalid1 = vld_p2 & port_p2;
   assign rdata0  = ram_r_data;
   assign rdata1  = ram_r_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, grant vector table, and a read-data
// scoreboard keyed by port and due cycle.
module tb_ram_arbiter;

   localparam logic [15:0] INIT = 16'h5A5A;

   logic        clk = 1'b0;
   logic        rst_n, req0, req1, we0, we1;
   logic [7:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, init_done, ram_w_en;
   logic [15:0] rdata0, rdata1, ram_w_data, ram_r_data;
   logic [7:0]  ram_w_addr, ram_r_addr;

   ram_arbiter #(.AW(8), .DW(16), .CLEAR_ON_RESET(1'b1), .INIT_DATA(INIT)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .init_done(init_done),
      .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_r_addr(ram_r_addr),
      .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [256];
   always @(posedge clk) begin
      if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
      ram_r_data <= mem[ram_r_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct { logic port; logic [15:0] data; int due; } sb_t;
   sb_t sb [$];
   sb_t mon_e;
   logic [15:0] ref_mem [256];
   logic mon_en = 1'b0;

   typedef struct {
      logic r0, r1, w0, w1;
      logic [7:0] a0, a1;
      logic [15:0] d0, d1;
      logic g0, g1;
   } vec_t;
   vec_t vecs [$];

   task automatic add(input logic r0, r1, w0, w1, input logic [7:0] a0, a1,
                      input logic [15:0] d0, d1, input logic g0, g1);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.a0 = a0; v.a1 = a1;
      v.d0 = d0; v.d1 = d1; v.g0 = g0; v.g1 = g1;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model the effect of a handshake the bench expects to happen this cycle.
   task automatic handshake(input logic port, input logic we, input logic [7:0] a,
                            input logic [15:0] d);
      sb_t e;
      if (we) ref_mem[a] = d;
      else begin
         e.port = port; e.data = ref_mem[a]; e.due = cyc + 2;
         sb.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (rvalid0 || rvalid1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL spurious_rvalid rvalid0=%b rvalid1=%b expected none (cycle %0d)",
                        rvalid0, rvalid1, cyc);
            end else begin
               mon_e = sb.pop_front();
               if ((rvalid0 && rvalid1) || rvalid1 != mon_e.port || cyc != mon_e.due ||
                   (mon_e.port ? rdata1 : rdata0) !== mon_e.data) begin
                  errors++;
                  $display("FAIL read_return rv0=%b rv1=%b data=%h cycle=%0d expected port=%0d data=%h cycle=%0d",
                           rvalid0, rvalid1, mon_e.port ? rdata1 : rdata0, cyc,
                           mon_e.port, mon_e.data, mon_e.due);
               end
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            mon_e = sb.pop_front();
            $display("FAIL missing_rvalid actual=none expected port=%0d data=%h cycle=%0d",
                     mon_e.port, mon_e.data, mon_e.due);
         end
      end
   end

   task automatic idle_inputs();
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
   endtask

   // Called in the first cycle with rst_n high; both ports request throughout CLEAR.
   task automatic wait_clear();
      int n;
      n = 0;
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'd3; addr1 = 8'd4;
      #1;
      while (n <= 300) begin
         if (init_done === 1'b1) break;
         chk("clear_gnt", {gnt0, gnt1}, 2'b00);
         if (n == 0) begin
            chk("rst_w_en", ram_w_en, 1'b0);
            chk("rst_w_addr", ram_w_addr, 8'd0);
            chk("rst_r_addr", ram_r_addr, 8'd0);
            chk("rst_w_data", ram_w_data, 16'h0);
            chk("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
         end else begin
            chk("clear_write", {ram_w_en, ram_w_addr, ram_w_data}, {1'b1, 8'(n - 1), INIT});
         end
         @(negedge clk); #1;
         n++;
      end
      chk("clear_len", n, 256);
      chk("first_grant_same_cycle", {gnt0, gnt1}, 2'b10);
      req0 = 0; req1 = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = INIT;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0;
      idle_inputs();
      req0 = 1; req1 = 1;
      @(negedge clk);
      @(negedge clk); #1;
      chk("reset_init_done", init_done, 1'b0);
      chk("reset_gnt", {gnt0, gnt1}, 2'b00);
      chk("reset_rvalid", {rvalid0, rvalid1}, 2'b00);
      chk("reset_w_en", ram_w_en, 1'b0);
      mon_en = 1'b1;
      @(negedge clk);
      rst_n = 1;
      wait_clear();

      //  r0 r1 w0 w1  a0     a1     d0        d1        g0 g1
      add(1, 0, 1, 0, 8'd10, 8'd0,  16'h000A, 16'h0,    1, 0);
      add(1, 0, 1, 0, 8'd11, 8'd0,  16'h000B, 16'h0,    1, 0);
      add(1, 0, 1, 0, 8'd12, 8'd0,  16'h000C, 16'h0,    1, 0);
      add(1, 0, 1, 0, 8'd1,  8'd0,  16'h1111, 16'h0,    1, 0);
      add(0, 1, 0, 1, 8'd0,  8'd2,  16'h0,    16'h2222, 0, 1);
      add(0, 0, 0, 0, 8'd0,  8'd0,  16'h0,    16'h0,    0, 0);
      add(1, 0, 0, 0, 8'd77, 8'd0,  16'h0,    16'h0,    1, 0);
      add(1, 0, 0, 0, 8'd10, 8'd0,  16'h0,    16'h0,    1, 0);
      add(1, 0, 0, 0, 8'd11, 8'd0,  16'h0,    16'h0,    1, 0);
      add(1, 0, 0, 0, 8'd12, 8'd0,  16'h0,    16'h0,    1, 0);
      add(0, 1, 0, 1, 8'd0,  8'd211,16'h0,    16'hDEAD, 0, 1);
      add(0, 1, 0, 0, 8'd0,  8'd211,16'h0,    16'h0,    0, 1);
      for (int i = 0; i < 6; i++)
         add(1, 1, 0, 0, 8'd1, 8'd2, 16'h0, 16'h0, (i % 2) == 0, (i % 2) == 1);
      add(0, 0, 0, 0, 8'd0,  8'd0,  16'h0,    16'h0,    0, 0);
      add(1, 1, 0, 0, 8'd2,  8'd1,  16'h0,    16'h0,    1, 0);
      add(0, 1, 0, 0, 8'd0,  8'd1,  16'h0,    16'h0,    0, 1);
      add(1, 1, 1, 1, 8'd50, 8'd51, 16'h0050, 16'h0051, 1, 0);
      add(0, 1, 0, 1, 8'd0,  8'd51, 16'h0,    16'h0051, 0, 1);
      add(1, 1, 0, 0, 8'd51, 8'd50, 16'h0,    16'h0,    1, 0);
      add(0, 1, 0, 0, 8'd0,  8'd50, 16'h0,    16'h0,    0, 1);

      foreach (vecs[i]) begin
         @(negedge clk);
         req0 = vecs[i].r0; req1 = vecs[i].r1; we0 = vecs[i].w0; we1 = vecs[i].w1;
         addr0 = vecs[i].a0; addr1 = vecs[i].a1; wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
         #1;
         chk($sformatf("vec%0d_gnt", i), {gnt0, gnt1}, {vecs[i].g0, vecs[i].g1});
         if (vecs[i].g0) handshake(1'b0, vecs[i].w0, vecs[i].a0, vecs[i].d0);
         if (vecs[i].g1) handshake(1'b1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      end
      @(negedge clk);
      idle_inputs();
      repeat (4) @(negedge clk);
      #1 chk("sb_drained_table", sb.size(), 0);

      // Idle hold after a write.
      req0 = 1; we0 = 1; addr0 = 8'd201; wdata0 = 16'hBEEF;
      #1 chk("hold_wr_gnt", {gnt0, gnt1}, 2'b10);
      @(negedge clk);
      idle_inputs();
      #1 chk("hold_wr_issue", {ram_w_en, ram_w_addr, ram_w_data}, {1'b1, 8'd201, 16'hBEEF});
      repeat (5) begin
         @(negedge clk); #1;
         chk("idle_hold", {ram_w_en, ram_w_addr, ram_w_data}, {1'b0, 8'd201, 16'hBEEF});
      end

      // Reset while a read is in flight.
      @(negedge clk);
      req0 = 1; we0 = 0; addr0 = 8'd10;
      #1 chk("inflight_gnt", {gnt0, gnt1}, 2'b10);
      @(negedge clk);
      req0 = 0; rst_n = 0;
      #1 chk("midreset_gnt_forced", {init_done, gnt0, gnt1}, 3'b000);
      @(negedge clk);
      rst_n = 1;
      wait_clear();

      // Address 201 must be cleared again.
      @(negedge clk);
      req0 = 1; we0 = 0; addr0 = 8'd201;
      #1 chk("post_clear_gnt", {gnt0, gnt1}, 2'b10);
      handshake(1'b0, 1'b0, 8'd201, 16'h0);
      @(negedge clk);
      idle_inputs();
      repeat (4) @(negedge clk);
      #1 chk("sb_drained_end", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
